game_log_uart_tx: RTL and testbench

//   Serial transmitter for game events. Sits beside the game core and the HEX/LED display path,
//   and sends each event to a host PC as one ASCII line on the UART TX pin.

---
 rtl/game_log_uart_tx.sv | 152 +++++++++++++++
 tb/tb_game_log_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_log_uart_tx.sv
// Game event UART transmitter: sends each accepted event as the 12-byte ASCII line
// "Gdddd Cc r\r\n" at 8N1, LSB first, with one idle cycle between bytes.
module game_log_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [15:0] ev_guess,
  input  logic [2:0]  ev_chances,
  input  logic [1:0]  ev_result,
  output logic        uart_txd,
  output logic        busy
);

  localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int            CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BYTE    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [3:0]    r_idx;
  logic [15:0]   r_guess;
  logic [2:0]    r_chances;
  logic [1:0]    r_result;
  logic          r_txd;
  logic [7:0]    w_char;

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F' (0x41 + n - 10 == 0x37 + n).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    w_char = 8'h20;
    case (r_idx)
      4'd0:    w_char = 8'h47;
      4'd1:    w_char = hex_ascii(r_guess[15:12]);
      4'd2:    w_char = hex_ascii(r_guess[11:8]);
      4'd3:    w_char = hex_ascii(r_guess[7:4]);
      4'd4:    w_char = hex_ascii(r_guess[3:0]);
      4'd5:    w_char = 8'h20;
      4'd6:    w_char = 8'h43;
      4'd7:    w_char = 8'h30 + {5'b0, r_chances};
      4'd8:    w_char = 8'h20;
      4'd9: begin
        case (r_result)
          2'd0:    w_char = 8'h4D;
          2'd1:    w_char = 8'h57;
          2'd2:    w_char = 8'h4C;
          default: w_char = 8'h3F;
        endcase
      end
      4'd10:   w_char = 8'h0D;
      4'd11:   w_char = 8'h0A;
      default: w_char = 8'h20;
    endcase
  end

  // NOTE: state is updated with <= so every branch sees the pre-edge values of all registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_idx     <= '0;
      r_guess   <= '0;
      r_chances <= '0;
      r_result  <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (ev_valid) begin
            r_guess   <= ev_guess;
            r_chances <= ev_chances;
            r_result  <= ev_result;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_txd     <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_txd   <= w_char[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_txd <= w_char[r_bit + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          // The start bit is driven here; w_char follows the new index by the time data begins.
          if (r_idx == LAST_BYTE) begin
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ev_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign uart_txd = r_txd;

endmodule

// File: tb/tb_game_log_uart_tx.sv
// Scoreboarded bench for game_log_uart_tx: a reference model queues expected line bytes,
// a UART receiver process decodes uart_txd and compares each byte as it completes.
module tb_game_log_uart_tx;

  localparam int CPB      = 4;
  localparam int LINE_CYC = 12 * (10 * CPB + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic [15:0] ev_guess = '0;
  logic [2:0]  ev_chances = '0;
  logic [1:0]  ev_result = '0;
  logic        ev_ready;
  logic        uart_txd;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  game_log_uart_tx #(.CLK_HZ(1000), .BAUD(250)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_guess  (ev_guess),
    .ev_chances(ev_chances),
    .ev_result (ev_result),
    .uart_txd  (uart_txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference model: the ASCII line the spec defines for an event.
  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic push_line(input logic [15:0] g, input int c, input int r);
    logic [7:0] res_tab[4];
    res_tab = '{8'h4D, 8'h57, 8'h4C, 8'h3F};
    exp_q.push_back(8'h47);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hex_char(int'((g >> (4 * i)) & 16'hF)));
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'(48 + c));
    exp_q.push_back(8'h20);
    exp_q.push_back(res_tab[r]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Monitor: UART receiver sampling on the falling edge; checks data, start/stop and bit stability.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    logic       s0;
    bit         ab;
    bit         fr_ok;
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        ab    = 1'b0;
        fr_ok = 1'b1;
        for (int k = 1; k < CPB; k++) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
          if (uart_txd !== 1'b0) fr_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          s0 = 1'b0;
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
            if (k == 0) s0 = uart_txd;
            else if (uart_txd !== s0) fr_ok = 1'b0;
          end
          d[b] = s0;
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (reset) ab = 1'b1;
          if (uart_txd !== 1'b1) fr_ok = 1'b0;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected none", d);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(d), 32'(e));
            check("rx_framing", 32'(fr_ok), 32'd1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ev_ready !== 1'b1 && n < 2 * LINE_CYC) begin
      tick(1);
      n++;
    end
    if (ev_ready !== 1'b1) timeout(name);
  endtask

  task automatic send(input logic [15:0] g, input logic [2:0] c, input logic [1:0] r, input bit hold);
    wait_ready("send_ready");
    ev_guess   = g;
    ev_chances = c;
    ev_result  = r;
    ev_valid   = 1'b1;
    push_line(g, int'(c), int'(r));
    tick(1);
    check("accept_ready_low", 32'(ev_ready), 32'd0);
    check("accept_busy_high", 32'(busy), 32'd1);
    if (!hold) ev_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad_idle;
    logic [15:0] g;

    tick(3);
    check("reset_txd", 32'(uart_txd), 32'd1);
    check("reset_ready", 32'(ev_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (uart_txd !== 1'b1 || ev_ready !== 1'b1) bad_idle++;
    end
    check("idle_line_high", 32'(bad_idle), 32'd0);

    // 1: basic line and exact busy length
    send(16'h1234, 3'd5, 2'd0, 1'b0);
    n = 1;
    while (busy === 1'b1 && n < 2 * LINE_CYC) begin
      tick(1);
      if (busy === 1'b1) n++;
    end
    check("busy_cycles", 32'(n), 32'(LINE_CYC));
    check("ready_after_line", 32'(ev_ready), 32'd1);

    // 2: hex letters and zero digit
    send(16'hAF09, 3'd0, 2'd1, 1'b0);

    // 3: valid held across two lines; second line starts one cycle after ready rises
    send(16'($urandom), 3'($urandom), 2'($urandom), 1'b1);
    g = 16'($urandom);
    ev_guess   = g;
    ev_chances = 3'd6;
    ev_result  = 2'd2;
    push_line(g, 6, 2);
    n = 0;
    while (ev_ready !== 1'b1 && n < 2 * LINE_CYC) begin
      tick(1);
      n++;
    end
    if (ev_ready !== 1'b1) timeout("b2b_ready");
    tick(1);
    check("b2b_start_bit", 32'(uart_txd), 32'd0);
    check("b2b_ready_low", 32'(ev_ready), 32'd0);
    ev_valid = 1'b0;

    // 4: inputs change mid-line
    send(16'h5C3E, 3'd4, 2'd2, 1'b0);
    tick(100);
    ev_guess   = 16'hFFFF;
    ev_chances = 3'd1;
    ev_result  = 2'd3;
    ev_valid   = 1'b0;

    // 5: reset during data bits of byte 3
    send(16'($urandom), 3'($urandom), 2'($urandom), 1'b0);
    tick(3 * (10 * CPB + 1) + CPB + 8);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    check("midreset_txd", 32'(uart_txd), 32'd1);
    check("midreset_ready", 32'(ev_ready), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(50);
    send(16'($urandom), 3'($urandom), 2'($urandom), 1'b0);

    // 6: max chances and '?' result
    send(16'($urandom), 3'd7, 2'd3, 1'b0);

    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 3'($urandom), 2'($urandom), 1'b0);
      tick(int'($urandom_range(0, 3)));
    end

    wait_ready("final_ready");
    tick(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
